// File: rtl/daq_pkg.sv
// Shared constants for the DAQ write-port arbiter: word width, header/revoke
// markers and FSM state encoding.
package daq_pkg;
    localparam int DAQ_WORD = 32;
    localparam logic [3:0]  HDR_NIBBLE  = 4'hA;
    localparam logic [15:0] REVOKE_MARK = 16'hdead;

    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ST_IDLE   = 2'd0;
    localparam arb_state_t ST_GRANT  = 2'd1;
    localparam arb_state_t ST_REVOKE = 2'd2;
endpackage

// File: rtl/daq_arbiter_rr_pick.sv
// Combinational round-robin finder: first set bit of req at or after ptr+1,
// wrapping modulo NDAQ.
module rr_pick
    import daq_pkg::*;
#(
    parameter int NDAQ = 5
) (
    input  logic [NDAQ-1:0] req,
    input  logic [3:0]      ptr,
    output logic            found,
    output logic [3:0]      idx
);
    logic [4:0]      cand [NDAQ];
    logic [NDAQ-1:0] hit;

    // hit[gi] is set when the channel gi+1 positions after ptr is requesting
    generate
        for (genvar gi = 0; gi < NDAQ; gi++) begin : g_cand
            logic [4:0] raw;
            assign raw       = {1'b0, ptr} + 5'(gi + 1);
            assign cand[gi]  = (raw >= 5'(NDAQ)) ? raw - 5'(NDAQ) : raw;
            assign hit[gi]   = |(req & (NDAQ'(1) << cand[gi]));
        end
    endgenerate

    always_comb begin
        found = |hit;
        idx   = 4'd0;
        for (int k = NDAQ - 1; k >= 0; k--) begin
            if (hit[k]) idx = cand[k][3:0];
        end
    end
endmodule

// File: rtl/daq_arbiter.sv
// Round-robin arbiter sharing the DAQ packet-buffer write port between NDAQ
// producers, with space reservation, word limit and stuck-grant watchdog.
// Optional message header word enabled by defining DAQ_ARB_HEADER_EN.
module daq_arbiter
    import daq_pkg::*;
#(
    parameter int NDAQ      = 5,
    parameter int FIFO_BITS = 9,
    parameter int MAX_MSG   = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DAQ_WORD*NDAQ-1:0] daq_data_in,
    input  logic [NDAQ-1:0]          daq_valid,
    input  logic [NDAQ-1:0]          daq_end,
    input  logic [NDAQ-1:0]          daq_req,
    output logic [NDAQ-1:0]          daq_grant,
    output logic [DAQ_WORD-1:0]      out_data,
    output logic                     out_valid,
    output logic                     out_end,
    input  logic [FIFO_BITS:0]       out_free,
    output logic [3:0]               chan,
    output logic [15:0]              timeout_cnt
);
    localparam int WCW = $clog2(MAX_MSG + 1);
`ifdef DAQ_ARB_HEADER_EN
    localparam int THRESH = MAX_MSG + 1;
`else
    localparam int THRESH = MAX_MSG;
`endif
    localparam logic [WCW-1:0] LAST_WORD  = WCW'(MAX_MSG - 1);
    localparam logic [7:0]     IDLE_LIMIT = 8'(TIMEOUT - 1);

    arb_state_t          state_reg;
    logic [NDAQ-1:0]     grant_reg;
    logic [3:0]          chan_reg;
    logic [3:0]          ptr_reg;
    logic [DAQ_WORD-1:0] out_data_reg;
    logic                out_valid_reg;
    logic                out_end_reg;
    logic [15:0]         timeout_cnt_reg;
    logic [7:0]          idle_reg;
    logic [WCW-1:0]      words_reg;
`ifdef DAQ_ARB_HEADER_EN
    logic [15:0]         seq_reg;
`endif

    logic                pick_found;
    logic [3:0]          pick_idx;
    logic                sel_valid;
    logic                sel_end;
    logic                space_ok;
    logic                at_limit;
    logic [DAQ_WORD-1:0] sel_data;
    logic [DAQ_WORD-1:0] data_masked [NDAQ];

    rr_pick #(.NDAQ(NDAQ)) u_pick (
        .req   (daq_req),
        .ptr   (ptr_reg),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // The one-hot grant doubles as the input select, so other channels never leak through
    assign sel_valid = |(daq_valid & grant_reg);
    assign sel_end   = |(daq_end & grant_reg);
    assign space_ok  = out_free >= (FIFO_BITS + 1)'(THRESH);
    assign at_limit  = (words_reg == LAST_WORD);

    generate
        for (genvar gi = 0; gi < NDAQ; gi++) begin : g_sel
            assign data_masked[gi] = grant_reg[gi] ? daq_data_in[gi*DAQ_WORD +: DAQ_WORD] : '0;
        end
    endgenerate

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NDAQ; k++) sel_data = sel_data | data_masked[k];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            grant_reg       <= '0;
            chan_reg        <= '0;
            ptr_reg         <= '0;
            out_data_reg    <= '0;
            out_valid_reg   <= 1'b0;
            out_end_reg     <= 1'b0;
            timeout_cnt_reg <= '0;
            idle_reg        <= '0;
            words_reg       <= '0;
`ifdef DAQ_ARB_HEADER_EN
            seq_reg         <= '0;
`endif
        end else begin
            out_valid_reg <= 1'b0;
            out_end_reg   <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (pick_found && space_ok) begin
                        grant_reg <= NDAQ'(1) << pick_idx;
                        chan_reg  <= pick_idx;
                        idle_reg  <= '0;
                        words_reg <= '0;
                        state_reg <= ST_GRANT;
`ifdef DAQ_ARB_HEADER_EN
                        out_valid_reg <= 1'b1;
                        out_data_reg  <= {HDR_NIBBLE, pick_idx, 8'd0, seq_reg};
                        seq_reg       <= seq_reg + 16'd1;
`endif
                    end
                end
                ST_GRANT: begin
                    if (sel_valid) begin
                        out_valid_reg <= 1'b1;
                        out_data_reg  <= sel_data;
                        out_end_reg   <= sel_end || at_limit;
                        words_reg     <= words_reg + 1'b1;
                        idle_reg      <= '0;
                        if (sel_end || at_limit) begin
                            grant_reg <= '0;
                            ptr_reg   <= chan_reg;
                            state_reg <= ST_IDLE;
                        end
                    end else if (idle_reg == IDLE_LIMIT) begin
                        // Close a partially forwarded message so the packer is not left hanging
                        if (words_reg != '0) begin
                            out_valid_reg <= 1'b1;
                            out_end_reg   <= 1'b1;
                            out_data_reg  <= {REVOKE_MARK, 12'd0, chan_reg};
                        end
                        if (timeout_cnt_reg != 16'hffff) timeout_cnt_reg <= timeout_cnt_reg + 16'd1;
                        grant_reg <= '0;
                        ptr_reg   <= chan_reg;
                        state_reg <= ST_REVOKE;
                    end else begin
                        idle_reg <= idle_reg + 8'd1;
                    end
                end
                ST_REVOKE: state_reg <= ST_IDLE;
                default:   state_reg <= ST_IDLE;
            endcase
        end
    end

    assign daq_grant   = grant_reg;
    assign out_data    = out_data_reg;
    assign out_valid   = out_valid_reg;
    assign out_end     = out_end_reg;
    assign chan        = chan_reg;
    assign timeout_cnt = timeout_cnt_reg;
endmodule
